// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, rounding helper and bench coefficients for fir_mc
package fir_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, OUTPUT} state_t;

  localparam int DEF_TAPS = 16;

  localparam logic signed [15:0] DEFAULT_COEF [DEF_TAPS] = '{
    -16'sd81,   -16'sd134,  16'sd318,   16'sd645,
    -16'sd1257, -16'sd2262, 16'sd4522,  16'sd14633,
    16'sd14633, 16'sd4522,  -16'sd2262, -16'sd1257,
    16'sd645,   16'sd318,   -16'sd134,  -16'sd81
  };

  // Round half up out of Q1.(coef_w-1), then clamp to a data_w-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int coef_w, input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    if (r > max_v)
      r = max_v;
    else if (r < min_v)
      r = min_v;
    return r;
  endfunction

endpackage

// File: rtl/fir_hist_bank.sv
// rtl/fir_hist_bank.sv - per-channel sample history shift registers with random read
module fir_hist_bank #(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  parameter int CHAN_W   = 1,
  parameter int ADDR_W   = 4
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [CHAN_W-1:0]        wr_chan,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [CHAN_W-1:0]        rd_chan,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          hist[c][t] <= '0;
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          hist[c][t] <= '0;
    end else if (shift) begin
      hist[wr_chan][0] <= wr_data;
      for (int t = 1; t < TAPS; t++)
        hist[wr_chan][t] <= hist[wr_chan][t-1];
    end
  end

  assign rd_data = hist[rd_chan][rd_addr];

endmodule

// File: rtl/fir_mc.sv
// rtl/fir_mc.sv - time-multiplexed multi-channel FIR with one MAC and shared coefficients
module fir_mc
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  localparam int ACC_W   = DATA_W + COEF_W + $clog2(TAPS),
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W  = $clog2(TAPS)
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CHAN_W-1:0]        in_chan,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CHAN_W-1:0]        out_chan,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     clear
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  state_t                   state, state_nx;
  logic [CHAN_W-1:0]        chan;
  logic signed [DATA_W-1:0] sample;
  logic [ADDR_W-1:0]        addr;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] hist_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       rnd;
  logic                     hist_shift, hist_clear;
  logic                     accept, chan_ok;

  assign accept  = in_valid && in_ready;
  assign chan_ok = int'(in_chan) < CHANNELS;
  assign prod    = PROD_W'(hist_q) * PROD_W'(coef[addr]);
  assign rnd     = sat_round(64'(acc), COEF_W, DATA_W);

  fir_hist_bank #(
    .DATA_W(DATA_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .CHAN_W(CHAN_W), .ADDR_W(ADDR_W)
  ) u_hist (
    .ck(ck), .rst(rst), .shift(hist_shift), .clear(hist_clear),
    .wr_chan(chan), .wr_data(sample),
    .rd_chan(chan), .rd_addr(addr), .rd_data(hist_q)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // clear wins over a same-edge accept; an out-of-range channel is simply not started
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept && !clear && chan_ok) state_nx = LOAD;
      LOAD:   state_nx = MAC;
      MAC:    if (addr == LAST) state_nx = ROUND;
      ROUND:  state_nx = OUTPUT;
      OUTPUT: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    hist_shift = (state == LOAD);
    hist_clear = (state == IDLE) && clear;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      chan      <= '0;
      sample    <= '0;
      addr      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        coef[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_data;
          if (accept) begin
            chan   <= in_chan;
            sample <= in_data;
          end
        end
        LOAD: begin
          acc  <= '0;
          addr <= '0;
        end
        MAC: begin
          acc  <= acc + ACC_W'(prod);
          addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
        ROUND: begin
          out_data  <= rnd[DATA_W-1:0];
          out_chan  <= chan;
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// tb/tb_fir_mc.sv - randomized and directed bench for fir_mc against a tap-sum reference model
module tb_fir_mc;
  import fir_pkg::*;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int TAPS     = 16;
  localparam int CHANNELS = 2;
  localparam int CHAN_W   = 1;
  localparam int ADDR_W   = 4;

  logic                     ck = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] in_data;
  logic [CHAN_W-1:0]        in_chan;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CHAN_W-1:0]        out_chan;
  logic                     out_valid;
  logic                     out_ready;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     clear;

  int tests = 0;
  int fails = 0;
  int hist_m [CHANNELS][TAPS];
  int coef_m [TAPS];
  int last_out;

  fir_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS)) dut (
    .ck(ck), .rst(rst), .in_data(in_data), .in_chan(in_chan), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clear(clear)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Filter output = saturated, half-up rounded dot product of history and coefficients.
  function automatic int model_out(input int ch);
    longint acc = 0;
    longint r;
    longint hi = (longint'(1) << (DATA_W - 1)) - 1;
    for (int i = 0; i < TAPS; i++)
      acc += longint'(hist_m[ch][i]) * longint'(coef_m[i]);
    r = (acc + (longint'(1) << (COEF_W - 2))) >>> (COEF_W - 1);
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return int'(r);
  endfunction

  function automatic int model_push(input int ch, input int d);
    for (int t = TAPS - 1; t > 0; t--)
      hist_m[ch][t] = hist_m[ch][t-1];
    hist_m[ch][0] = d;
    return model_out(ch);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++)
      for (int t = 0; t < TAPS; t++)
        hist_m[c][t] = 0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = ADDR_W'(a); coef_data = COEF_W'(d);
    @(posedge ck); #1;
    coef_we = 1'b0;
    coef_m[a] = d;
  endtask

  task automatic do_clear(input bit with_accept);
    clear = 1'b1; in_valid = with_accept; in_chan = '0; in_data = 16'sd12345;
    @(posedge ck); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge ck);
    #1;
    chk("clear_stays_idle", in_ready, 1);
    chk("clear_no_output", out_valid, 0);
  endtask

  // Send one sample and consume its result; busy_wr pulses a coef[0] write during MAC.
  task automatic push(input int ch, input int d, input bit busy_wr);
    int n;
    int exp;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_chan = ch[CHAN_W-1:0]; in_data = DATA_W'(d);
    @(posedge ck); #1;
    in_valid = 1'b0;
    exp = model_push(ch, d);
    n = 0;
    while (!out_valid && n < 100) begin
      if (busy_wr && n == 3) begin
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd1000;
      end else begin
        coef_we = 1'b0;
      end
      @(posedge ck); #1;
      n++;
    end
    coef_we = 1'b0;
    chk("latency", n, TAPS + 2);
    chk("out_data", out_data, exp);
    chk("out_chan", out_chan, ch);
    last_out = int'(out_data);
    @(posedge ck); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int d;
    int n;
    int exp;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clear = 1'b0;
    model_clear();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    rst = 1'b0;
    @(posedge ck); #1;

    // impulse response with the default lowpass
    for (int i = 0; i < TAPS; i++) write_coef(i, int'(DEFAULT_COEF[i]));
    push(0, 32767, 0);
    chk("impulse_first", last_out, -81);
    for (int k = 1; k < TAPS; k++) push(0, 0, 0);

    // random interleaved traffic
    for (int k = 0; k < 10; k++) begin
      d = int'($urandom_range(65535)) - 32768;
      push(int'($urandom_range(1)), d, 0);
    end

    // channel independence
    do_clear(0);
    for (int k = 0; k < 8; k++) begin
      push(0, (k == 0) ? 16384 : 0, 0);
      push(1, 0, 0);
      chk("ch1_silent", last_out, 0);
    end

    // saturation at both rails
    for (int i = 0; i < TAPS; i++) write_coef(i, 16384);
    do_clear(0);
    for (int k = 0; k < TAPS; k++) push(0, 32767, 0);
    chk("sat_pos", last_out, 32767);
    for (int k = 0; k < TAPS; k++) push(0, -32768, 0);
    chk("sat_neg", last_out, -32768);

    // backpressure
    for (int i = 0; i < TAPS; i++) write_coef(i, int'(DEFAULT_COEF[i]));
    out_ready = 1'b0;
    d = int'($urandom_range(65535)) - 32768;
    in_valid = 1'b1; in_chan = 1'b1; in_data = DATA_W'(d);
    @(posedge ck); #1;
    in_valid = 1'b0;
    exp = model_push(1, d);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge ck); #1; n++; end
    chk("bp_latency", n, TAPS + 2);
    for (int k = 0; k < 20; k++) begin
      @(posedge ck); #1;
      chk("bp_hold", {out_valid, in_ready, out_chan, out_data}, {1'b1, 1'b0, 1'b1, DATA_W'(exp)});
    end
    out_ready = 1'b1;
    @(posedge ck); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // coefficient write while busy is ignored; in IDLE it takes effect
    push(0, int'($urandom_range(20000)) + 1000, 1);
    write_coef(0, 1000);
    push(0, int'($urandom_range(20000)) + 1000, 0);

    // clear with a same-edge accept after the history is full
    for (int k = 0; k < 4; k++) push(0, int'($urandom_range(65535)) - 32768, 0);
    do_clear(1);
    d = int'($urandom_range(65535)) - 32768;
    push(0, d, 0);
    chk("clear_single_tap", last_out, int'((longint'(d) * 1000 + 16384) >>> 15));

    // reset in the middle of MAC
    in_valid = 1'b1; in_chan = '0; in_data = 16'sd20000;
    @(posedge ck); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge ck);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge ck); #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    for (int k = 0; k < 3; k++) push(0, int'($urandom_range(65535)) - 32768, 0);
    chk("midrst_zero_out", last_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
